vend_controller: RTL and testbench



---
 rtl/vend_controller.sv | 195 +++++++++++++++++++
 tb/tb_vend_controller.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending machine sequencer: keypad selection, price/stock check, coin credit,
// dispense, and greedy change/refund one coin per cycle.
module vend_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter logic [39:0] INIT_INV       = 40'hFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_cancel,
  input  logic        coin_valid,
  input  logic [1:0]  coin_type,
  input  logic        restock,
  input  logic [10:0] price_in,
  output logic [3:0]  sel1,
  output logic [3:0]  sel2,
  output logic [3:0]  sel3,
  output logic [39:0] inventory,
  output logic [10:0] credit,
  output logic        coin_reject,
  output logic        dispense_valid,
  output logic [5:0]  dispense_idx,
  output logic        change_valid,
  output logic [1:0]  change_coin,
  output logic        err_valid,
  output logic [1:0]  err_code
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY2, S_KEY3, S_LOOKUP, S_PAY, S_VEND, S_CHANGE
  } state_t;

  state_t           state, state_n;
  logic [3:0]       sel1_n, sel2_n, sel3_n;
  logic [39:0]      inv_n;
  logic [10:0]      credit_n;
  logic [9:0]       price, price_n;
  logic [CNT_W-1:0] tcnt, tcnt_n;
  logic             rej_n, disp_n, chg_n, err_n;
  logic [5:0]       idx_n, slot_idx;
  logic [1:0]       coin_n, code_n;
  logic [10:0]      coin_val;
  logic             timeout, abort, timed_state;

  // sel1 is always 1 on this machine, so only (sel2, sel3) pick the slot
  always_comb begin
    case (sel2)
      4'd4:    slot_idx = 6'd20 + {2'b00, sel3};
      4'd6:    slot_idx = 6'd35 + {2'b00, sel3};
      default: slot_idx = ({2'b00, sel2} * 6'd5) + {3'b000, sel3[3:1]};
    endcase
  end

  always_comb begin
    case (coin_type)
      2'b00:   coin_val = 11'd5;
      2'b01:   coin_val = 11'd10;
      2'b10:   coin_val = 11'd25;
      default: coin_val = 11'd100;
    endcase
  end

  assign timed_state = (state == S_KEY2) || (state == S_KEY3) || (state == S_PAY);
  assign timeout     = timed_state && (tcnt == TO_LAST);
  assign abort       = key_cancel || timeout;

  always_comb begin
    state_n  = state;
    sel1_n   = sel1;
    sel2_n   = sel2;
    sel3_n   = sel3;
    inv_n    = inventory;
    credit_n = credit;
    price_n  = price;
    rej_n    = 1'b0;
    disp_n   = 1'b0;
    chg_n    = 1'b0;
    err_n    = 1'b0;
    idx_n    = dispense_idx;
    coin_n   = change_coin;
    code_n   = err_code;

    if (coin_valid && state != S_PAY) rej_n = 1'b1;

    case (state)
      S_IDLE: begin
        if (key_valid) begin
          sel1_n  = key_digit;
          state_n = S_KEY2;
        end
        if (restock) inv_n = INIT_INV;
      end
      S_KEY2: begin
        if (abort) begin
          err_n = 1'b1; code_n = 2'b11; state_n = S_CHANGE;
        end else if (key_valid) begin
          sel2_n = key_digit; state_n = S_KEY3;
        end
      end
      S_KEY3: begin
        if (abort) begin
          err_n = 1'b1; code_n = 2'b11; state_n = S_CHANGE;
        end else if (key_valid) begin
          sel3_n = key_digit; state_n = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (price_in[9:0] == 10'd0) begin
          err_n = 1'b1; code_n = 2'b01; state_n = S_IDLE;
        end else if (!price_in[10]) begin
          err_n = 1'b1; code_n = 2'b10; state_n = S_IDLE;
        end else begin
          price_n = price_in[9:0]; state_n = S_PAY;
        end
      end
      S_PAY: begin
        // a coin landing with a cancel is still credited, then refunded in CHANGE
        if (coin_valid) credit_n = credit + coin_val;
        if (abort) begin
          err_n = 1'b1; code_n = 2'b11; state_n = S_CHANGE;
        end else if (credit >= {1'b0, price}) begin
          state_n = S_VEND;
        end
      end
      S_VEND: begin
        disp_n   = 1'b1;
        idx_n    = slot_idx;
        if (slot_idx < 6'd40) inv_n[slot_idx] = 1'b0;
        credit_n = credit - {1'b0, price};
        state_n  = S_CHANGE;
      end
      S_CHANGE: begin
        if (credit != 11'd0) begin
          chg_n = 1'b1;
          if (credit >= 11'd25) begin
            coin_n = 2'b10; credit_n = credit - 11'd25;
          end else if (credit >= 11'd10) begin
            coin_n = 2'b01; credit_n = credit - 11'd10;
          end else begin
            coin_n = 2'b00; credit_n = credit - 11'd5;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (state_n != state || key_valid || key_cancel || coin_valid || !timed_state)
      tcnt_n = '0;
    else
      tcnt_n = tcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      sel1           <= '0;
      sel2           <= '0;
      sel3           <= '0;
      inventory      <= INIT_INV;
      credit         <= '0;
      price          <= '0;
      tcnt           <= '0;
      coin_reject    <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_idx   <= '0;
      change_valid   <= 1'b0;
      change_coin    <= '0;
      err_valid      <= 1'b0;
      err_code       <= '0;
    end else begin
      state          <= state_n;
      sel1           <= sel1_n;
      sel2           <= sel2_n;
      sel3           <= sel3_n;
      inventory      <= inv_n;
      credit         <= credit_n;
      price          <= price_n;
      tcnt           <= tcnt_n;
      coin_reject    <= rej_n;
      dispense_valid <= disp_n;
      dispense_idx   <= idx_n;
      change_valid   <= chg_n;
      change_coin    <= coin_n;
      err_valid      <= err_n;
      err_code       <= code_n;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboarded bench for vend_controller: expected pulse events are queued with
// the stimulus and matched in order against pulses seen on the outputs.
module tb_vend_controller;

  localparam int unsigned TO   = 16;
  localparam logic [39:0] INIT = 40'hFF_FFFF_FFFF;
  localparam logic [1:0]  K_DISP = 2'd0, K_CHG = 2'd1, K_ERR = 2'd2, K_REJ = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = '0;
  logic        key_cancel = 1'b0;
  logic        coin_valid = 1'b0;
  logic [1:0]  coin_type = '0;
  logic        restock = 1'b0;
  logic [10:0] price_in = '0;
  logic [3:0]  sel1, sel2, sel3;
  logic [39:0] inventory;
  logic [10:0] credit;
  logic        coin_reject, dispense_valid, change_valid, err_valid;
  logic [5:0]  dispense_idx;
  logic [1:0]  change_coin, err_code;

  always #5 clk = ~clk;

  vend_controller #(.TIMEOUT_CYCLES(TO), .INIT_INV(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .key_cancel(key_cancel), .coin_valid(coin_valid), .coin_type(coin_type),
    .restock(restock), .price_in(price_in), .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .inventory(inventory), .credit(credit), .coin_reject(coin_reject),
    .dispense_valid(dispense_valid), .dispense_idx(dispense_idx),
    .change_valid(change_valid), .change_coin(change_coin),
    .err_valid(err_valid), .err_code(err_code)
  );

  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [39:0] inv_model = INIT;

  function automatic logic [7:0] ev(input logic [1:0] k, input logic [5:0] v);
    return {k, v};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (dispense_valid) obs_q.push_back(ev(K_DISP, dispense_idx));
      if (change_valid)   obs_q.push_back(ev(K_CHG, {4'd0, change_coin}));
      if (err_valid)      obs_q.push_back(ev(K_ERR, {4'd0, err_code}));
      if (coin_reject)    obs_q.push_back(ev(K_REJ, 6'd0));
    end
  end

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1; coin_type = t;
    @(posedge clk); #1;
    coin_valid = 1'b0;
  endtask

  task automatic coin_cancel(input logic [1:0] t);
    coin_valid = 1'b1; coin_type = t; key_cancel = 1'b1;
    @(posedge clk); #1;
    coin_valid = 1'b0; key_cancel = 1'b0;
  endtask

  task automatic cancel();
    key_cancel = 1'b1;
    @(posedge clk); #1;
    key_cancel = 1'b0;
  endtask

  task automatic restock_pulse();
    restock = 1'b1;
    @(posedge clk); #1;
    restock = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic select(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    key(a); key(b); key(c);
  endtask

  task automatic test_reset();
    checks++;
    if ({sel1, sel2, sel3} !== 12'h000) begin
      errors++; $display("FAIL reset_sel got %h exp 000", {sel1, sel2, sel3});
    end
    checks++;
    if (credit !== 11'd0) begin
      errors++; $display("FAIL reset_credit got %0d exp 0", credit);
    end
    checks++;
    if (inventory !== INIT) begin
      errors++; $display("FAIL reset_inventory got %h exp %h", inventory, INIT);
    end
    checks++;
    if ({coin_reject, dispense_valid, change_valid, err_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses got %b exp 0000",
                         {coin_reject, dispense_valid, change_valid, err_valid});
    end
    checks++;
    if ({dispense_idx, change_coin, err_code} !== 10'd0) begin
      errors++; $display("FAIL reset_fields got %h exp 0", {dispense_idx, change_coin, err_code});
    end
  endtask

  task automatic test_exact_pay();
    price_in = 11'h464;
    select(4'd1, 4'd0, 4'd0);
    checks++;
    if ({sel1, sel2, sel3} !== 12'h100) begin
      errors++; $display("FAIL t1_sel got %h exp 100", {sel1, sel2, sel3});
    end
    tick();
    repeat (4) coin(2'b10);
    exp_q.push_back(ev(K_DISP, 6'd0));
    inv_model[0] = 1'b0;
    settle(5);
    coin(2'b00);
    exp_q.push_back(ev(K_REJ, 6'd0));
    settle(3);
    checks++;
    if (inventory !== inv_model) begin
      errors++; $display("FAIL t1_inventory got %h exp %h", inventory, inv_model);
    end
    checks++;
    if (credit !== 11'd0) begin
      errors++; $display("FAIL t1_credit got %0d exp 0", credit);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t1_event_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL t1_event got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_change();
    price_in = {1'b1, 10'd25};
    select(4'd1, 4'd6, 4'd4);
    checks++;
    if ({sel1, sel2, sel3} !== 12'h164) begin
      errors++; $display("FAIL t2_sel got %h exp 164", {sel1, sel2, sel3});
    end
    tick();
    coin(2'b11);
    exp_q.push_back(ev(K_DISP, 6'd39));
    inv_model[39] = 1'b0;
    @(negedge clk);
    checks++;
    if (credit !== 11'd100) begin
      errors++; $display("FAIL t2_credit_in got %0d exp 100", credit);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!(dispense_valid === 1'b1 && dispense_idx === 6'd39 && credit === 11'd75)) begin
      errors++; $display("FAIL t2_vend got v=%b idx=%0d credit=%0d exp v=1 idx=39 credit=75",
                         dispense_valid, dispense_idx, credit);
    end
    for (int i = 0; i < 3; i++) begin
      logic [10:0] want;
      want = 11'(50 - 25 * i);
      exp_q.push_back(ev(K_CHG, 6'd2));
      @(negedge clk);
      checks++;
      if (!(change_valid === 1'b1 && change_coin === 2'b10 && credit === want)) begin
        errors++; $display("FAIL t2_change%0d got v=%b coin=%b credit=%0d exp v=1 coin=10 credit=%0d",
                           i, change_valid, change_coin, credit, want);
      end
    end
    settle(4);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t2_event_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL t2_event got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_invalid_slot();
    price_in = 11'h000;
    select(4'd1, 4'd0, 4'd1);
    exp_q.push_back(ev(K_ERR, 6'd1));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!(err_valid === 1'b1 && err_code === 2'b01)) begin
      errors++; $display("FAIL t3_err_timing got v=%b code=%b exp v=1 code=01", err_valid, err_code);
    end
    tick();
    coin(2'b01);
    exp_q.push_back(ev(K_REJ, 6'd0));
    settle(3);
    checks++;
    if (credit !== 11'd0) begin
      errors++; $display("FAIL t3_credit got %0d exp 0", credit);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t3_event_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL t3_event got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_sold_out_restock();
    price_in = {1'b1, 10'd5};
    select(4'd1, 4'd4, 4'd3);
    tick();
    coin(2'b00);
    exp_q.push_back(ev(K_DISP, 6'd23));
    inv_model[23] = 1'b0;
    settle(5);
    checks++;
    if (inventory !== inv_model) begin
      errors++; $display("FAIL t4_inventory got %h exp %h", inventory, inv_model);
    end
    price_in = {1'b0, 10'd5};
    select(4'd1, 4'd4, 4'd3);
    exp_q.push_back(ev(K_ERR, 6'd2));
    settle(3);
    key(4'd1);
    restock_pulse();
    checks++;
    if (inventory !== inv_model) begin
      errors++; $display("FAIL t4_restock_ignored got %h exp %h", inventory, inv_model);
    end
    cancel();
    exp_q.push_back(ev(K_ERR, 6'd3));
    settle(4);
    restock_pulse();
    inv_model = INIT;
    settle(1);
    checks++;
    if (inventory !== inv_model) begin
      errors++; $display("FAIL t4_restock got %h exp %h", inventory, inv_model);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t4_event_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL t4_event got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_cancel_refund();
    price_in = {1'b1, 10'd125};
    select(4'd1, 4'd2, 4'd0);
    tick();
    coin(2'b01);
    coin(2'b00);
    checks++;
    if (credit !== 11'd15) begin
      errors++; $display("FAIL t5_credit got %0d exp 15", credit);
    end
    cancel();
    exp_q.push_back(ev(K_ERR, 6'd3));
    exp_q.push_back(ev(K_CHG, 6'd1));
    exp_q.push_back(ev(K_CHG, 6'd0));
    settle(5);
    checks++;
    if (credit !== 11'd0 || inventory !== inv_model) begin
      errors++; $display("FAIL t5_end got credit=%0d inv=%h exp credit=0 inv=%h",
                         credit, inventory, inv_model);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t5_event_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL t5_event got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout_and_coin_cancel();
    int n;
    price_in = {1'b1, 10'd100};
    select(4'd1, 4'd3, 4'd2);
    tick();
    coin(2'b10);
    exp_q.push_back(ev(K_ERR, 6'd3));
    exp_q.push_back(ev(K_CHG, 6'd2));
    n = 0;
    @(negedge clk);
    while (err_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL t6_timeout_latency got %0d exp 16", n);
    end
    settle(4);
    select(4'd1, 4'd3, 4'd3);
    tick();
    coin(2'b10);
    coin_cancel(2'b01);
    checks++;
    if (credit !== 11'd35) begin
      errors++; $display("FAIL t6_coin_cancel_credit got %0d exp 35", credit);
    end
    exp_q.push_back(ev(K_ERR, 6'd3));
    exp_q.push_back(ev(K_CHG, 6'd2));
    exp_q.push_back(ev(K_CHG, 6'd1));
    settle(5);
    checks++;
    if (credit !== 11'd0) begin
      errors++; $display("FAIL t6_credit_end got %0d exp 0", credit);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t6_event_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL t6_event got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_change();
    price_in = {1'b1, 10'd5};
    select(4'd1, 4'd0, 4'd5);
    tick();
    coin(2'b11);
    exp_q.push_back(ev(K_DISP, 6'd2));
    exp_q.push_back(ev(K_CHG, 6'd2));
    settle(4);
    #2 rst_n = 1'b0;
    #1;
    inv_model = INIT;
    checks++;
    if (credit !== 11'd0 || inventory !== inv_model) begin
      errors++; $display("FAIL t7_reset got credit=%0d inv=%h exp credit=0 inv=%h",
                         credit, inventory, inv_model);
    end
    settle(2);
    rst_n = 1'b1;
    settle(6);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t7_event_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL t7_event got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    settle(3);
    test_reset();
    rst_n = 1'b1;
    tick();
    test_exact_pay();
    test_change();
    test_invalid_slot();
    test_sold_out_restock();
    test_cancel_refund();
    test_timeout_and_coin_cancel();
    test_reset_mid_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
